// File: rtl/bdma_ahb_if.sv
// AHB-Lite bus bundle between the BDMA master port and the responder slave.
interface bdma_ahb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned UW = 4
) ();
    logic          hsel;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [AW-1:0] haddr;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic          hmasterlock;
    logic [3:0]    hprot;
    logic [3:0]    hmaster;
    logic [UW-1:0] hauser;
    logic [UW-1:0] hwuser;
    logic [DW-1:0] hwdata;
    logic          hreadym;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic [UW-1:0] hruser;

    modport master (
        output hsel, htrans, hwrite, haddr, hsize, hburst, hmasterlock, hprot,
               hmaster, hauser, hwuser, hwdata, hreadym,
        input  hreadyout, hresp, hrdata, hruser
    );

    modport slave (
        input  hsel, htrans, hwrite, haddr, hsize, hburst, hmasterlock, hprot,
               hmaster, hauser, hwuser, hwdata, hreadym,
        output hreadyout, hresp, hrdata, hruser
    );
endinterface

// File: rtl/bdma_ahb_responder.sv
// AHB-Lite SRAM responder for the BDMA master port with programmable wait states.
// Define BDMA_RESP_ERRCHK_EN to return ERROR for out-of-window, oversize or misaligned transfers.
module bdma_ahb_responder #(
    parameter int unsigned   AW    = 32,
    parameter int unsigned   DW    = 32,
    parameter int unsigned   UW    = 4,
    parameter int unsigned   DEPTH = 1024,
    parameter logic [AW-1:0] BASE  = AW'(32'h6100_0000),
    parameter int unsigned   WAIT  = 0
) (
    input  logic      aclk,
    input  logic      reset,
    bdma_ahb_if.slave bus
);
    localparam int unsigned   IW       = $clog2(DEPTH);
    localparam int unsigned   BW       = DW / 8;
    localparam int unsigned   CW       = 4;
    localparam bit            HAS_WAIT = (WAIT > 0);
    localparam logic [CW-1:0] CNT_LOAD = HAS_WAIT ? CW'(WAIT - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITST,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic logic [BW-1:0] lane_be(input logic [2:0] size, input logic [1:0] off);
        logic [BW-1:0] be;
        case (size)
            3'd0:    be = BW'(1) << off;
            3'd1:    be = off[1] ? BW'(4'b1100) : BW'(4'b0011);
            default: be = '1;
        endcase
        return be;
    endfunction

    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old,
                                                  input logic [DW-1:0] wd,
                                                  input logic [BW-1:0] be);
        logic [DW-1:0] w;
        w = old;
        for (int unsigned b = 0; b < BW; b++) begin
            if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        return w;
    endfunction

    logic [DW-1:0] mem [DEPTH];

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          hready_q, hresp_q;
    logic [DW-1:0] hrdata_q;
    logic [UW-1:0] hruser_q;

    logic          a_write;
    logic [IW-1:0] a_idx;
    logic [BW-1:0] a_be;
    logic [UW-1:0] a_user;

    logic          open_c, accept_c, err_c, wr_en_c, rd_write_c;
    logic [IW-1:0] rd_idx_c;
    logic [UW-1:0] rd_user_c;
    logic [DW-1:0] wr_word_c, rd_word_c;
    logic          unused_c;

    // New address phases are only sampled while our own data phase is completing or absent.
    assign open_c   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept_c = open_c && bus.hsel && bus.htrans[1] && bus.hreadym;

`ifdef BDMA_RESP_ERRCHK_EN
    assign err_c = (bus.haddr[AW-1:IW+2] != BASE[AW-1:IW+2])
                || (bus.hsize > 3'd2)
                || ((bus.hsize == 3'd1) && bus.haddr[0])
                || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
`else
    assign err_c = 1'b0;
`endif

    assign unused_c = ^{bus.htrans[0], bus.hburst, bus.hmasterlock, bus.hprot,
                        bus.hmaster, bus.hwuser, bus.haddr[AW-1:IW+2]};

    // Write commits at the end of the DONE cycle, when hwdata is valid.
    assign wr_en_c   = (state == ST_DONE) && a_write;
    assign wr_word_c = merge_lanes(mem[a_idx], bus.hwdata, a_be);

    // Read source: the live address when entering DONE directly, else the captured one.
    assign rd_idx_c   = accept_c ? bus.haddr[IW+1:2] : a_idx;
    assign rd_user_c  = accept_c ? bus.hauser : a_user;
    assign rd_write_c = accept_c ? bus.hwrite : a_write;
    assign rd_word_c  = (wr_en_c && (a_idx == rd_idx_c)) ? wr_word_c : mem[rd_idx_c];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_WAITST: begin
                if (cnt == '0) state_nx = ST_DONE;
                else           cnt_nx   = cnt - CW'(1);
            end
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = ST_IDLE;
        endcase
        if (accept_c) begin
            if (err_c) begin
                state_nx = ST_ERR1;
            end else if (HAS_WAIT) begin
                state_nx = ST_WAITST;
                cnt_nx   = CNT_LOAD;
            end else begin
                state_nx = ST_DONE;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
            hruser_q <= '0;
            a_write  <= 1'b0;
            a_idx    <= '0;
            a_be     <= '0;
            a_user   <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            hready_q <= !((state_nx == ST_WAITST) || (state_nx == ST_ERR1));
            hresp_q  <= (state_nx == ST_ERR1) || (state_nx == ST_ERR2);
            if (accept_c) begin
                a_write <= bus.hwrite;
                a_idx   <= bus.haddr[IW+1:2];
                a_be    <= lane_be(bus.hsize, bus.haddr[1:0]);
                a_user  <= bus.hauser;
            end
            if ((state_nx == ST_DONE) && !rd_write_c) begin
                hrdata_q <= rd_word_c;
                hruser_q <= rd_user_c;
            end else if ((state_nx == ST_ERR1) && !rd_write_c) begin
                hrdata_q <= '0;
            end
        end
    end

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge aclk) begin
        if (wr_en_c && !reset) mem[a_idx] <= wr_word_c;
    end

    assign bus.hreadyout = hready_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.hruser    = hruser_q;
endmodule
